// File: rtl/font_rom_arbiter.sv
// font_rom_arbiter: round-robin arbiter that shares one combinational font ROM
// among NUM_REQ glyph-row requesters. Each fetch takes two cycles:
// GRANT, when the ROM is addressed, then DATA, when the response is strobed.
module font_rom_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int CODE_W  = 6,
    parameter int ROW_W   = 3
) (
    input  logic                        Clk,
    input  logic                        Reset_n,
    input  logic [NUM_REQ-1:0]          req,
    input  logic [NUM_REQ*CODE_W-1:0]   req_code,
    input  logic [NUM_REQ*ROW_W-1:0]    req_row,
    input  logic                        pause,
    output logic [NUM_REQ-1:0]          gnt,
    output logic [NUM_REQ-1:0]          rsp_valid,
    output logic [7:0]                  rsp_data,
    output logic [CODE_W+ROW_W-1:0]     rom_addr,
    input  logic [7:0]                  rom_data,
    output logic                        busy
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {IDLE, GRANT, DATA} state_t;

    state_t                     r_state, w_state_nxt;
    logic [PTR_W-1:0]           r_ptr;
    logic [NUM_REQ-1:0]         r_gnt;
    logic [NUM_REQ-1:0]         r_rsp_valid;
    logic [7:0]                 r_rsp_data;
    logic [CODE_W+ROW_W-1:0]    r_rom_addr;

    logic [PTR_W-1:0]           w_win;
    logic [PTR_W-1:0]           w_ptr_nxt;
    logic                       w_found;
    logic                       w_arb;
    logic [NUM_REQ-1:0]         w_onehot;
    logic [CODE_W-1:0]          w_code;
    logic [ROW_W-1:0]           w_row;

    // Round-robin search: the first set req bit starting at r_ptr, wrapping modulo NUM_REQ.
    // The sum is one bit wider so that the wrap works for NUM_REQ that are not a power of two.
    always_comb begin
        logic [PTR_W:0] sum;
        logic [PTR_W-1:0] idx;
        w_found = 1'b0;
        w_win   = '0;
        sum     = '0;
        idx     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            sum = {1'b0, r_ptr} + (PTR_W+1)'(k);
            if (sum >= (PTR_W+1)'(NUM_REQ))
                sum = sum - (PTR_W+1)'(NUM_REQ);
            idx = sum[PTR_W-1:0];
            if (!w_found && req[idx]) begin
                w_found = 1'b1;
                w_win   = idx;
            end
        end
    end

    // Winner decode: arbitration is allowed only outside GRANT and only while pause is low.
    always_comb begin
        w_arb     = (r_state != GRANT) && !pause && w_found;
        w_onehot  = NUM_REQ'(1) << w_win;
        w_code    = req_code[int'(w_win)*CODE_W +: CODE_W];
        w_row     = req_row[int'(w_win)*ROW_W +: ROW_W];
        w_ptr_nxt = (w_win == PTR_W'(NUM_REQ-1)) ? '0 : w_win + PTR_W'(1);
    end

    // State register
    always_ff @(posedge Clk) begin
        if (!Reset_n) r_state <= IDLE;
        else          r_state <= w_state_nxt;
    end

    // Next-state logic: DATA chains straight into GRANT when another request is ready
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_arb) w_state_nxt = GRANT;
            GRANT:   w_state_nxt = DATA;
            DATA:    w_state_nxt = w_arb ? GRANT : IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Datapath: grant and ROM address on arbitration; ROM capture and response strobe in GRANT
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            r_ptr       <= '0;
            r_gnt       <= '0;
            r_rsp_valid <= '0;
            r_rsp_data  <= '0;
            r_rom_addr  <= '0;
        end else begin
            r_gnt       <= '0;
            r_rsp_valid <= '0;
            if (r_state == GRANT) begin
                r_rsp_valid <= r_gnt;
                r_rsp_data  <= rom_data;
            end
            if (w_arb) begin
                r_gnt      <= w_onehot;
                r_rom_addr <= {w_code, w_row};
                r_ptr      <= w_ptr_nxt;
            end
        end
    end

    assign gnt       = r_gnt;
    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign rom_addr  = r_rom_addr;
    assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_font_rom_arbiter.sv
// Directed bench for font_rom_arbiter, using a small combinational model of the font ROM.
module tb_font_rom_arbiter;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic [2:0]  req;
    logic [17:0] req_code;
    logic [8:0]  req_row;
    logic        pause;
    logic [2:0]  gnt;
    logic [2:0]  rsp_valid;
    logic [7:0]  rsp_data;
    logic [8:0]  rom_addr;
    logic [7:0]  rom_data;
    logic        busy;

    int errors = 0;
    int checks = 0;

    font_rom_arbiter #(.NUM_REQ(3), .CODE_W(6), .ROW_W(3)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .req(req), .req_code(req_code),
        .req_row(req_row), .pause(pause), .gnt(gnt), .rsp_valid(rsp_valid),
        .rsp_data(rsp_data), .rom_addr(rom_addr), .rom_data(rom_data), .busy(busy)
    );

    always #5 Clk = ~Clk;

    // Font ROM model: address 0x02B holds 0x06; every other address holds its low byte XOR 0xA5.
    function automatic logic [7:0] rom_model(input logic [8:0] a);
        if (a == 9'h02B) return 8'h06;
        return a[7:0] ^ 8'hA5;
    endfunction
    assign rom_data = rom_model(rom_addr);

    // Hand-computed {code,row} for requesters 0/1/2: {05,3}=02B, {0A,1}=051, {11,2}=08A
    function automatic logic [8:0] exp_addr(input int w);
        case (w)
            0:       return 9'h02B;
            1:       return 9'h051;
            default: return 9'h08A;
        endcase
    endfunction

    function automatic logic [7:0] exp_data(input int w);
        case (w)
            0:       return 8'h06;
            1:       return 8'hF4;
            default: return 8'h2F;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and sample 1 time unit after the edge; also check that grant
    // and response strobes are each at most one-hot and never active together.
    task automatic step();
        @(posedge Clk);
        #1;
        chk("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
        chk("rsp_onehot0", 32'($onehot0(rsp_valid)), 32'd1);
        chk("gnt_rsp_excl", 32'((|gnt) && (|rsp_valid)), 32'd0);
    endtask

    initial begin
        Reset_n  = 1'b0;
        req      = 3'b000;
        pause    = 1'b0;
        req_code = {6'h11, 6'h0A, 6'h05};
        req_row  = {3'd2, 3'd1, 3'd3};

        // Reset state
        step(); step();
        chk("rst_gnt", 32'(gnt), 32'h0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rst_rsp_data", 32'(rsp_data), 32'h0);
        chk("rst_rom_addr", 32'(rom_addr), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);

        // Single fetch by requester 0
        Reset_n = 1'b1;
        req = 3'b001;
        step();
        chk("s1_gnt", 32'(gnt), 32'h1);
        chk("s1_rom_addr", 32'(rom_addr), 32'h02B);
        chk("s1_busy", 32'(busy), 32'h1);
        req = 3'b000;
        step();
        chk("s1_rsp_valid", 32'(rsp_valid), 32'h1);
        chk("s1_rsp_data", 32'(rsp_data), 32'h06);
        step();
        chk("s1_idle_busy", 32'(busy), 32'h0);
        chk("s1_idle_rsp", 32'(rsp_valid), 32'h0);

        // ptr is now 1: req=101 -> requester 2 first, then requester 0 directly from DATA
        req = 3'b101;
        step();
        chk("s3_gnt2", 32'(gnt), 32'h4);
        chk("s3_addr2", 32'(rom_addr), 32'h08A);
        req = 3'b001;
        step();
        chk("s3_rsp2", 32'(rsp_valid), 32'h4);
        chk("s3_data2", 32'(rsp_data), 32'h2F);
        step();
        chk("s3_gnt0", 32'(gnt), 32'h1);
        chk("s3_addr0", 32'(rom_addr), 32'h02B);
        req = 3'b000;
        step();
        chk("s3_rsp0", 32'(rsp_valid), 32'h1);
        chk("s3_data0", 32'(rsp_data), 32'h06);
        step();
        chk("s3_idle", 32'(busy), 32'h0);

        // From reset, req=111 held for six fetches: order 0,1,2,0,1,2, one grant every 2 cycles
        Reset_n = 1'b0;
        step();
        Reset_n = 1'b1;
        req = 3'b111;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("s2_gnt", 32'(gnt), 32'(3'b001 << (i % 3)));
            chk("s2_addr", 32'(rom_addr), 32'(exp_addr(i % 3)));
            if (i == 5) req = 3'b000;
            step();
            chk("s2_rsp", 32'(rsp_valid), 32'(3'b001 << (i % 3)));
            chk("s2_data", 32'(rsp_data), 32'(exp_data(i % 3)));
            chk("s2_gnt_low", 32'(gnt), 32'h0);
        end
        step();
        chk("s2_idle", 32'(busy), 32'h0);

        // pause blocks arbitration while idle
        pause = 1'b1;
        req = 3'b010;
        step();
        chk("p_gnt", 32'(gnt), 32'h0);
        chk("p_busy", 32'(busy), 32'h0);
        step();
        chk("p_gnt2", 32'(gnt), 32'h0);
        pause = 1'b0;
        step();
        chk("p_gnt1", 32'(gnt), 32'h2);
        // pause raised during GRANT: response still issued, then IDLE
        pause = 1'b1;
        step();
        chk("p_rsp1", 32'(rsp_valid), 32'h2);
        chk("p_data1", 32'(rsp_data), 32'hF4);
        step();
        chk("p_idle_busy", 32'(busy), 32'h0);
        chk("p_idle_gnt", 32'(gnt), 32'h0);
        chk("p_idle_rsp", 32'(rsp_valid), 32'h0);
        pause = 1'b0;
        req = 3'b000;
        step();

        // Reset during GRANT (ptr would otherwise be 2 after granting requester 1)
        req = 3'b010;
        step();
        chk("r_gnt1", 32'(gnt), 32'h2);
        Reset_n = 1'b0;
        req = 3'b000;
        step();
        chk("r_gnt", 32'(gnt), 32'h0);
        chk("r_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("r_rsp_data", 32'(rsp_data), 32'h0);
        chk("r_rom_addr", 32'(rom_addr), 32'h0);
        chk("r_busy", 32'(busy), 32'h0);
        Reset_n = 1'b1;
        step();
        chk("r_no_rsp", 32'(rsp_valid), 32'h0);
        req = 3'b111;
        step();
        chk("r_gnt0_first", 32'(gnt), 32'h1);
        req = 3'b000;
        step();
        chk("r_rsp0", 32'(rsp_valid), 32'h1);
        step();

        // req dropped as gnt rises: response still delivered, then IDLE with data held
        req = 3'b100;
        step();
        chk("d_gnt", 32'(gnt), 32'h4);
        req = 3'b000;
        step();
        chk("d_rsp", 32'(rsp_valid), 32'h4);
        chk("d_data", 32'(rsp_data), 32'h2F);
        step();
        chk("d_busy", 32'(busy), 32'h0);
        chk("d_rsp_low", 32'(rsp_valid), 32'h0);
        chk("d_data_hold", 32'(rsp_data), 32'h2F);
        chk("d_addr_hold", 32'(rom_addr), 32'h08A);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
